// File: rtl/mem_responder.sv
// mem_responder: bus responder between a 32-bit load/store request port and
// two on-chip memories: a combinational 32-bit flash (read-only) and a
// synchronous 8-bit RAM. Each accepted request yields exactly one response.
// Multi-byte RAM accesses are sequenced one byte per cycle, little-endian.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready   request handshake; accepted when both are high
//   req_addr, req_we        byte address, 1 = write
//   req_size                0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_wdata               write data, low N byte lanes used
//   rsp_valid               one-cycle response strobe
//   rsp_rdata, rsp_err      read data (zero-extended) and error flag
//   flash_addr, flash_data  flash word address and combinational read data
//   ram_rw, ram_addr        RAM write strobe (1 = write) and byte address
//   ram_di, ram_do          RAM write data, read data (valid one cycle later)
module mem_responder #(
    parameter int          flash_width = 9,
    parameter int          ram_width   = 10,
    parameter logic [31:0] ram_base    = 32'h1000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_addr,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [flash_width-1:0] flash_addr,
    input  logic [31:0]            flash_data,
    output logic                   ram_rw,
    output logic [ram_width-1:0]   ram_addr,
    output logic [7:0]             ram_di,
    input  logic [7:0]             ram_do
);

    typedef enum logic [2:0] {IDLE, FLASH, RAM_RD, RAM_WR, RESP} state_t;

    localparam logic [31:0] flash_bytes = 32'd4 << flash_width;
    localparam logic [31:0] ram_bytes   = 32'd1 << ram_width;

    state_t      state;
    logic [1:0]  lane_q;    // addr[1:0] of the request, for flash lane shift
    logic [1:0]  size_q;
    logic [1:0]  last_q;    // N-1: index of the final byte
    logic [2:0]  cnt;       // byte / cycle counter within a RAM access
    logic [31:0] wdata_q;   // write data, shifted down one byte per written byte
    logic [31:0] data_q;    // RAM read bytes collected so far

    // Request decode, only meaningful in the accept cycle.
    logic [31:0] ram_off;
    logic        in_flash, in_ram, misaligned, req_err;

    assign ram_off    = req_addr - ram_base;
    assign in_flash   = req_addr < flash_bytes;
    assign in_ram     = (req_addr >= ram_base) && (ram_off < ram_bytes);
    assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    assign req_err    = (req_size == 2'd3) || misaligned ||
                        !(in_flash || in_ram) || (in_flash && req_we);

    // Byte lane that the RAM data arriving this cycle belongs to: the read
    // issued in the previous cycle, hence cnt-1.
    logic [1:0] rd_idx;
    assign rd_idx = cnt[1:0] - 2'd1;

    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            2'd0:    lane_mask = 32'h0000_00FF;
            2'd1:    lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch sees the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            ram_rw     <= 1'b0;
            ram_addr   <= '0;
            ram_di     <= '0;
            flash_addr <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            last_q     <= '0;
            cnt        <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is always high here, so req_valid means accept.
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        lane_q    <= req_addr[1:0];
                        size_q    <= req_size;
                        // size 0/1/2 -> N-1 = 0/1/3
                        last_q    <= {req_size[1], req_size[1] | req_size[0]};
                        cnt       <= '0;
                        wdata_q   <= req_wdata;
                        data_q    <= '0;
                        if (req_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (in_flash) begin
                            state      <= FLASH;
                            flash_addr <= req_addr[flash_width+1:2];
                        end else if (req_we) begin
                            state    <= RAM_WR;
                            ram_rw   <= 1'b1;
                            ram_addr <= ram_off[ram_width-1:0];
                            ram_di   <= req_wdata[7:0];
                        end else begin
                            state    <= RAM_RD;
                            ram_addr <= ram_off[ram_width-1:0];
                        end
                    end
                end

                FLASH: begin
                    rsp_rdata <= (flash_data >> {lane_q, 3'b000}) & lane_mask(size_q);
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end

                RAM_RD: begin
                    // Cycle cnt presents address byte cnt and receives byte cnt-1.
                    cnt <= cnt + 3'd1;
                    if (cnt != 3'd0)
                        data_q[{rd_idx, 3'b000} +: 8] <= ram_do;
                    if (cnt == {1'b0, last_q} + 3'd1) begin
                        rsp_rdata <= data_q | ({24'd0, ram_do} << {rd_idx, 3'b000});
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt < {1'b0, last_q}) begin
                        ram_addr <= ram_addr + ram_width'(1);
                    end
                end

                RAM_WR: begin
                    if (cnt[1:0] == last_q) begin
                        ram_rw    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt      <= cnt + 3'd1;
                        ram_addr <= ram_addr + ram_width'(1);
                        ram_di   <= wdata_q[15:8];
                        wdata_q  <= wdata_q >> 8;
                    end
                end

                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    ram_rw    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: behavioural flash and RAM models, a table of
// directed request vectors, and hand-written sequences for the write trace,
// back-to-back acceptance and mid-transaction reset.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [8:0]  flash_addr;
    logic [31:0] flash_data;
    logic        ram_rw;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_di;
    logic [7:0]  ram_do;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .ram_rw     (ram_rw),
        .ram_addr   (ram_addr),
        .ram_di     (ram_di),
        .ram_do     (ram_do)
    );

    // Flash: word i = 0xC0DE0000 | i, except word 2 = 0xDEADBEEF.
    logic [31:0] flash_mem [0:511];
    assign flash_data = flash_mem[flash_addr];

    // RAM: byte i initialised to i[7:0] ^ 0xA5.
    logic [7:0] ram_mem [0:1023];
    logic       ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= 8'(i) ^ 8'hA5;
        end else if (ram_rw) begin
            ram_mem[ram_addr] <= ram_di;
        end else begin
            ram_do <= ram_mem[ram_addr];
        end
    end

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Observations from the most recent run_req.
    logic [8:0] fa_t1;
    int         wr_n;
    logic [9:0] wr_addr [0:7];
    logic [7:0] wr_di   [0:7];
    int         wr_cyc  [0:7];

    task automatic run_req(input string name, input logic [31:0] addr, input logic we,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int          lat;
        logic        got, rw_seen, err;
        logic [31:0] rdata;
        lat = 0; got = 1'b0; rw_seen = 1'b0; err = 1'b0; rdata = '0; wr_n = 0;
        @(negedge clk);
        check({name, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = addr; req_we = we; req_size = size; req_wdata = wdata;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance: the DUT must have registered them.
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_we = ~we; req_size = 2'd3; req_wdata = '0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (c == 1) fa_t1 = flash_addr;
            if (ram_rw) begin
                rw_seen = 1'b1;
                if (wr_n < 8) begin
                    wr_addr[wr_n] = ram_addr; wr_di[wr_n] = ram_di; wr_cyc[wr_n] = c;
                    wr_n++;
                end
            end
            if (rsp_valid) begin
                got = 1'b1; lat = c; rdata = rsp_rdata; err = rsp_err;
            end
        end
        check({name, ".latency"}, 32'(lat), 32'(exp_lat));
        check({name, ".rdata"}, rdata, exp_rdata);
        check({name, ".err"}, {31'd0, err}, {31'd0, exp_err});
        if (exp_err) check({name, ".no_ram_write"}, {31'd0, rw_seen}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [0:17];

    initial begin
        int pulses, n_acc;
        int acc_cyc [0:1];
        int rsp_cyc [0:3];
        logic [31:0] rsp_d [0:3];

        for (int i = 0; i < 512; i++) flash_mem[i] = 32'hC0DE_0000 | 32'(i);
        flash_mem[2] = 32'hDEAD_BEEF;

        vecs[0]  = '{32'h1000_0010, 1'b0, 2'd2, 32'h0,         32'h1122_3344, 1'b0, 6};
        vecs[1]  = '{32'h1000_0013, 1'b0, 2'd0, 32'h0,         32'h0000_0011, 1'b0, 3};
        vecs[2]  = '{32'h1000_0012, 1'b0, 2'd1, 32'h0,         32'h0000_1122, 1'b0, 4};
        vecs[3]  = '{32'h0000_000A, 1'b0, 2'd1, 32'h0,         32'h0000_DEAD, 1'b0, 2};
        vecs[4]  = '{32'h0000_0009, 1'b0, 2'd0, 32'h0,         32'h0000_00BE, 1'b0, 2};
        vecs[5]  = '{32'h0000_07FC, 1'b0, 2'd2, 32'h0,         32'hC0DE_01FF, 1'b0, 2};
        vecs[6]  = '{32'h1000_0020, 1'b1, 2'd0, 32'h1234_56AB, 32'h0,         1'b0, 2};
        vecs[7]  = '{32'h1000_0020, 1'b0, 2'd1, 32'h0,         32'h0000_84AB, 1'b0, 4};
        vecs[8]  = '{32'h1000_03FC, 1'b0, 2'd2, 32'h0,         32'h5A5B_5859, 1'b0, 6};
        vecs[9]  = '{32'h0000_0002, 1'b0, 2'd2, 32'h0,         32'h0,         1'b1, 1};
        vecs[10] = '{32'h0000_0000, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0,         1'b1, 1};
        vecs[11] = '{32'h2000_0000, 1'b0, 2'd2, 32'h0,         32'h0,         1'b1, 1};
        vecs[12] = '{32'h1000_0000, 1'b0, 2'd3, 32'h0,         32'h0,         1'b1, 1};
        vecs[13] = '{32'h1000_0001, 1'b0, 2'd1, 32'h0,         32'h0,         1'b1, 1};
        vecs[14] = '{32'h1000_0400, 1'b0, 2'd2, 32'h0,         32'h0,         1'b1, 1};
        vecs[15] = '{32'h0000_0800, 1'b0, 2'd2, 32'h0,         32'h0,         1'b1, 1};
        vecs[16] = '{32'h0FFF_FFFF, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 1};
        vecs[17] = '{32'h1000_0041, 1'b1, 2'd1, 32'h0000_BBCC, 32'h0,         1'b1, 1};

        rst_n = 1'b0; ram_init = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_size = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 ram_init = 1'b0;

        // Reset values, sampled while reset is held and after release.
        @(negedge clk);
        check("reset.ready", {31'd0, req_ready}, 32'd1);
        check("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset.rdata", rsp_rdata, 32'd0);
        check("reset.ram_rw", {31'd0, ram_rw}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.ready", {31'd0, req_ready}, 32'd1);
        check("idle.rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Flash word read: flash_addr 2 during T+1, response at T+2.
        run_req("flash_word", 32'h0000_0008, 1'b0, 2'd2, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
        check("flash_word.flash_addr", {23'd0, fa_t1}, 32'd2);

        // RAM word write: bytes 0x44,0x33,0x22,0x11 to 0x10..0x13 over T+1..T+4.
        run_req("ram_wr_word", 32'h1000_0010, 1'b1, 2'd2, 32'h1122_3344, 32'h0, 1'b0, 5);
        check("ram_wr_word.count", 32'(wr_n), 32'd4);
        check("ram_wr_word.a0", {22'd0, wr_addr[0]}, 32'h10);
        check("ram_wr_word.d0", {24'd0, wr_di[0]}, 32'h44);
        check("ram_wr_word.c0", 32'(wr_cyc[0]), 32'd1);
        check("ram_wr_word.a1", {22'd0, wr_addr[1]}, 32'h11);
        check("ram_wr_word.d1", {24'd0, wr_di[1]}, 32'h33);
        check("ram_wr_word.a2", {22'd0, wr_addr[2]}, 32'h12);
        check("ram_wr_word.d2", {24'd0, wr_di[2]}, 32'h22);
        check("ram_wr_word.a3", {22'd0, wr_addr[3]}, 32'h13);
        check("ram_wr_word.d3", {24'd0, wr_di[3]}, 32'h11);
        check("ram_wr_word.c3", 32'(wr_cyc[3]), 32'd4);

        for (int i = 0; i < 18; i++)
            run_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].size,
                    vecs[i].wdata, vecs[i].rdata, vecs[i].err, vecs[i].lat);

        // Back-to-back byte reads with req_valid held high.
        pulses = 0; n_acc = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1000_0010; req_we = 1'b0; req_size = 2'd0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (rsp_valid && pulses < 4) begin
                rsp_cyc[pulses] = c; rsp_d[pulses] = rsp_rdata; pulses++;
            end
            if (req_valid && req_ready && n_acc < 2) begin
                acc_cyc[n_acc] = c; n_acc++;
                if (n_acc == 2) begin
                    @(posedge clk);
                    #1 req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        check("b2b.accepts", 32'(n_acc), 32'd2);
        check("b2b.pulses", 32'(pulses), 32'd2);
        check("b2b.first_rsp", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd3);
        check("b2b.second_accept", 32'(acc_cyc[1] - rsp_cyc[0]), 32'd1);
        check("b2b.second_rsp", 32'(rsp_cyc[1] - acc_cyc[1]), 32'd3);
        check("b2b.rdata0", rsp_d[0], 32'h44);
        check("b2b.rdata1", rsp_d[1], 32'h44);

        // Reset at T+2 of a RAM word write to 0x1000_0030.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1000_0030; req_we = 1'b1; req_size = 2'd2;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid.ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid.ram_rw", {31'd0, ram_rw}, 32'd0);
        check("rst_mid.ram_addr", {22'd0, ram_addr}, 32'd0);
        check("rst_mid.ram_di", {24'd0, ram_di}, 32'd0);
        check("rst_mid.flash_addr", {23'd0, flash_addr}, 32'd0);
        check("rst_mid.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("rst_mid.no_rsp", 32'(pulses), 32'd0);
        check("rst_mid.ready_after", {31'd0, req_ready}, 32'd1);
        check("rst_mid.byte0_written", {24'd0, ram_mem[10'h30]}, 32'h0D);
        check("rst_mid.byte1_untouched", {24'd0, ram_mem[10'h31]}, 32'h94);
        run_req("post_rst_read", 32'h1000_0030, 1'b0, 2'd2, 32'h0, 32'h9697_940D, 1'b0, 6);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
